clock_ctrl: RTL and testbench
=============================

CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 Parameter WIDTH, default 28: width of the counter and divisor.
REQ-002 Parameter DEFAULT_DIV, default 100_000: divisor loaded at reset.
REQ-003 Parameter START_RUN, default 1: state after reset (1 = RUN, 0 = HALT).
REQ-004 clk_in  input  1: single system clock; all logic is on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 run  input  1: level; 1 requests free-running, 0 requests halt.
REQ-007 step  input  1: one-cycle pulse; requests exactly one output period while halted.
REQ-008 div_in  input  WIDTH: new divisor value.
REQ-009 div_load  input  1: one-cycle strobe that captures div_in.
REQ-010 clk_out  output  1: divided clock, registered.
REQ-011 rise_tick  output  1: one-cycle pulse in the cycle clk_out goes 0->1.
REQ-012 fall_tick  output  1: one-cycle pulse in the cycle clk_out goes 1->0.
REQ-013 halted  output  1: high while the FSM is in HALT.
REQ-014 div_cur  output  WIDTH: the active divisor.

Function
REQ-015 The active divisor D SHALL define the output period as D clk_in cycles; the counter SHALL count 0..D-1 and wrap to 0 ("boundary" = the cycle with counter == D-1).
REQ-016 clk_out SHALL be registered: clk_out(t+1) = (counter(t) < D>>1) while RUN or STEP, giving D>>1 high cycles and D-(D>>1) low cycles.
REQ-017 rise_tick and fall_tick SHALL be registered alongside clk_out and SHALL assert exactly in the cycle clk_out changes.
REQ-018 Any captured divisor below 2 SHALL be clamped to 2; divisor arithmetic SHALL be unsigned WIDTH-bit with no overflow path.
REQ-019 div_load SHALL latch the clamped div_in into a pending register and set a pending flag; a later div_load before the pending value is applied SHALL overwrite it.
REQ-020 A pending divisor SHALL become active at the next boundary in RUN or STEP, or on the next cycle in HALT; div_load coincident with a boundary SHALL apply the new value at that boundary.
REQ-021 FSM states are RUN, HALT and STEP.
REQ-022 RUN -> HALT when run == 0 at a boundary; the current period always completes, and clk_out is left low.
REQ-023 HALT -> RUN when run == 1; the counter restarts at 0, so the first rise_tick follows one cycle later.
REQ-024 HALT -> STEP on step == 1 with run == 0; exactly one full period runs from counter 0, then the FSM returns to HALT at the boundary.
REQ-025 If run == 1 at the STEP boundary, the FSM SHALL go to RUN with no gap cycle.
REQ-026 step SHALL be ignored in RUN and STEP, and when asserted in HALT together with run (run wins).
REQ-027 In HALT the counter SHALL hold at 0, clk_out SHALL be 0, and both ticks SHALL be 0.

Reset
REQ-028 On rst: counter = 0, clk_out = 0, rise_tick = 0, fall_tick = 0, pending flag cleared, div_cur = max(DEFAULT_DIV, 2), and state = RUN if START_RUN else HALT.
REQ-029 rst asserted mid-period SHALL abort the period immediately with no trailing tick; rst overrides run, step and div_load in the same cycle.

Structure
REQ-030 The package clock_pkg SHALL hold the FSM state enum, the minimum-divisor constant (2) and the default WIDTH.
REQ-031 The design SHALL be a single module with no sub-module; the counter, FSM and divisor registers are too tightly coupled to split.

Verification (DEFAULT_DIV = 4, START_RUN = 1)
REQ-032 Release reset, run = 1 -> clk_out toggles 1,1,0,0 repeating; rise_tick every 4 cycles; halted = 0.
REQ-033 div_load with div_in = 6 mid-period -> div_cur changes at the next boundary; the following periods are 3 high and 3 low; div_in = 0 or 1 -> div_cur = 2.
REQ-034 Drop run mid-high-phase -> the period completes, then halted = 1 and clk_out = 0 constant; raising run again -> rise_tick one cycle later.
REQ-035 In HALT, pulse step -> exactly one rise_tick and one fall_tick, then halted = 1; step pulses during STEP or RUN -> no extra periods.
REQ-036 Assert rst during the high phase -> clk_out = 0 next cycle with no fall_tick; div_cur = 4; with START_RUN = 0, halted = 1 after reset.
REQ-037 div_load in HALT with div_in = 8, then step -> a single period of 8 cycles (4 high, 4 low).

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the programmable clock divider.
// Holds the FSM encoding, the divisor floor and the default width.
package clock_pkg;

  localparam int DEF_WIDTH = 28;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

endpackage

// File: rtl/clock_ctrl.sv
// Programmable clock divider with run/halt/single-step control.
// Output period is div_cur cycles; divisor changes land on period edges.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = 100_000,
  parameter bit START_RUN   = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             halted,
  output logic [WIDTH-1:0] div_cur
);

  localparam logic [WIDTH-1:0] MIN_D = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] RST_DIV =
    (DEFAULT_DIV < MIN_DIV) ? MIN_D : WIDTH'(DEFAULT_DIV);
  localparam state_t RST_ST = START_RUN ? ST_RUN : ST_HALT;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pval_q, pval_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             rise_q, fall_q;
  logic [WIDTH-1:0] ld_val;
  logic             bnd;

  assign ld_val = (div_in < MIN_D) ? MIN_D : div_in;
  assign bnd    = (cnt_q == div_q - 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    clk_d   = 1'b0;
    if (div_load) begin
      pend_d = 1'b1;
      pval_d = ld_val;
    end
    unique case (state_q)
      ST_RUN, ST_STEP: begin
        clk_d = (cnt_q < (div_q >> 1));
        if (bnd) begin
          cnt_d   = '0;
          state_d = run ? ST_RUN : ST_HALT;
          // a load in the boundary cycle wins over an older pending value
          if (div_load) begin
            div_d  = ld_val;
            pend_d = 1'b0;
          end else if (pend_q) begin
            div_d  = pval_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HALT: begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = pval_q;
          pend_d = div_load;
        end
        if (run) begin
          state_d = ST_RUN;
        end else if (step) begin
          state_d = ST_STEP;
        end
      end
      default: begin
        state_d = ST_HALT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
      div_q   <= RST_DIV;
      pval_q  <= RST_DIV;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      rise_q  <= clk_d & ~clk_q;
      fall_q  <= ~clk_d & clk_q;
    end
  end

  assign clk_out   = clk_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
  assign halted    = (state_q == ST_HALT);
  assign div_cur   = div_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed plus random bench for clock_ctrl against a period-level model.
// A second instance covers the halted-after-reset configuration.
module tb_clock_ctrl;

  localparam int W = 28;
  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_STEP = 2;

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b1;
  logic         step = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         div_load = 1'b0;
  logic         clk_out, rise_tick, fall_tick, halted;
  logic [W-1:0] div_cur;

  logic         run2 = 1'b0;
  logic         step2 = 1'b0;
  logic         load2 = 1'b0;
  logic [W-1:0] din2 = '0;
  logic         clk_out2, rise2, fall2, halted2;
  logic [W-1:0] div_cur2;

  int checks = 0;
  int errors = 0;

  int      m_mode;
  longint  m_pos;
  longint  m_d;
  longint  m_pv;
  bit      m_pend;
  bit      m_clk, m_rise, m_fall;

  always #5 clk_in = ~clk_in;

  clock_ctrl #(.WIDTH(W), .DEFAULT_DIV(4), .START_RUN(1'b1)) dut (
    .clk_in(clk_in), .rst(rst), .run(run), .step(step),
    .div_in(div_in), .div_load(div_load),
    .clk_out(clk_out), .rise_tick(rise_tick), .fall_tick(fall_tick),
    .halted(halted), .div_cur(div_cur)
  );

  clock_ctrl #(.WIDTH(W), .DEFAULT_DIV(4), .START_RUN(1'b0)) dut2 (
    .clk_in(clk_in), .rst(rst), .run(run2), .step(step2),
    .div_in(din2), .div_load(load2),
    .clk_out(clk_out2), .rise_tick(rise2), .fall_tick(fall2),
    .halted(halted2), .div_cur(div_cur2)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint clampv(input longint v);
    return (v < 2) ? 2 : v;
  endfunction

  // Model: a period of m_d cycles, high for the first m_d/2 positions.
  task automatic model_edge();
    bit     was;
    bit     last;
    longint nv;
    was = m_clk;
    nv  = clampv(longint'(div_in));
    if (rst) begin
      m_mode = M_RUN; m_pos = 0; m_d = 4; m_pend = 0;
      m_clk = 0; m_rise = 0; m_fall = 0;
      return;
    end
    if (m_mode == M_HALT) begin
      m_clk = 0;
      if (m_pend) m_d = m_pv;
      m_pend = div_load;
      if (div_load) m_pv = nv;
      if (run) m_mode = M_RUN;
      else if (step) m_mode = M_STEP;
    end else begin
      m_clk = (m_pos < m_d / 2);
      last = (m_pos == m_d - 1);
      if (last) begin
        m_pos = 0;
        if (div_load) begin
          m_d = nv; m_pend = 0;
        end else if (m_pend) begin
          m_d = m_pv; m_pend = 0;
        end
        m_mode = run ? M_RUN : M_HALT;
      end else begin
        m_pos++;
        if (div_load) begin
          m_pend = 1; m_pv = nv;
        end
      end
    end
    m_rise = m_clk && !was;
    m_fall = !m_clk && was;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
    chk("clk_out", clk_out, m_clk);
    chk("rise_tick", rise_tick, m_rise);
    chk("fall_tick", fall_tick, m_fall);
    chk("halted", halted, (m_mode == M_HALT));
    chk("div_cur", div_cur, m_d);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input longint v);
    div_in = W'(v);
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
  endtask

  task automatic wait_high();
    for (int i = 0; i < 20 && clk_out !== 1'b1; i++) tick();
    chk("wait_high", clk_out, 1);
  endtask

  initial begin
    m_mode = M_RUN; m_pos = 0; m_d = 4; m_pv = 4; m_pend = 0;
    m_clk = 0; m_rise = 0; m_fall = 0;
    ticks(2);
    chk("rst_div", div_cur, 4);
    chk("rst_halted2", halted2, 1);
    chk("rst_div2", div_cur2, 4);
    rst = 1'b0;
    ticks(13);
    ticks(1);
    load(6);
    ticks(20);
    load(0);
    ticks(14);
    chk("clamp0", div_cur, 2);
    load(1);
    ticks(6);
    chk("clamp1", div_cur, 2);
    load(4);
    ticks(8);
    wait_high();
    run = 1'b0;
    ticks(10);
    chk("halt_after_drop", halted, 1);
    run = 1'b1;
    ticks(6);
    run = 1'b0;
    ticks(8);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    ticks(8);
    load(8);
    ticks(3);
    chk("halt_load8", div_cur, 8);
    step = 1'b1;
    tick();
    step = 1'b0;
    ticks(12);
    step = 1'b1;
    run = 1'b1;
    tick();
    step = 1'b0;
    ticks(10);
    wait_high();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_clk", clk_out, 0);
    chk("rst_mid_fall", fall_tick, 0);
    chk("halted2_idle", halted2, 1);
    chk("clk_out2_idle", clk_out2, 0);
    ticks(6);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      step = ($urandom_range(0, 7) == 0);
      div_load = ($urandom_range(0, 9) == 0);
      div_in = W'($urandom_range(0, 9));
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
